// File: rtl/bpred_btb_pkg.sv
// Purpose : shared helpers for the BTB branch predictor (address fields, counter init/saturation).
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Helpers work on widened operands so any legal XLEN/IDX_W/TAG_W/CTR_W
// instantiation can call them; callers cast results back to their widths.
package bpred_btb_pkg;

  // Widest counter the saturating helpers support.
  localparam int CW_MAX = 8;
  typedef logic [CW_MAX-1:0] ctr_t;

  // Counter reset value: weakly not-taken, 2^(w-1)-1.
  function automatic ctr_t ctr_init_nt(input int w);
    return (ctr_t'(1) << (w - 1)) - ctr_t'(1);
  endfunction

  // Counter value on allocation: weakly taken, 2^(w-1).
  function automatic ctr_t ctr_alloc_t(input int w);
    return ctr_t'(1) << (w - 1);
  endfunction

  function automatic ctr_t sat_inc(input ctr_t c, input int w);
    ctr_t mx;
    mx = (ctr_t'(1) << w) - ctr_t'(1);
    return (c == mx) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c, input int w);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

  function automatic logic [63:0] pc_field(input logic [63:0] pc, input int lsb, input int w);
    return (pc >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

  // idx = pc[IDX_W+1:2]
  function automatic logic [63:0] idx_of(input logic [63:0] pc, input int idx_w);
    return pc_field(pc, 2, idx_w);
  endfunction

  // tag = pc[IDX_W+1+TAG_W:IDX_W+2]
  function automatic logic [63:0] tag_of(input logic [63:0] pc, input int idx_w, input int tag_w);
    return pc_field(pc, idx_w + 2, tag_w);
  endfunction

endpackage

// File: rtl/bpred_btb_if.sv
// Purpose : IF-lookup and EX-resolution bus between core and bpred_btb.
// Latency : lookup combinational; mispredict/redirect registered one cycle after upd_valid.
// Backpressure: none; lookups and updates are accepted every cycle.
// master = core side, slave = predictor side.
interface bpred_btb_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 6
);
  logic             pred_valid;
  logic [XLEN-1:0]  pred_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [GHR_W-1:0] pred_ghr;

  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_is_branch;
  logic             upd_is_jump;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic [GHR_W-1:0] upd_ghr;

  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [31:0]      perf_branches;
  logic [31:0]      perf_mispredicts;

  modport master (
    output pred_valid, pred_pc,
    output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target, upd_ghr,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
    input  mispredict, redirect_pc, perf_branches, perf_mispredicts
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target, upd_ghr,
    output pred_hit, pred_taken, pred_target, pred_ghr,
    output mispredict, redirect_pc, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/bpred_btb_pht.sv
// Purpose : table of ENTRIES saturating CTR_W-bit counters, one comb read port, one write port.
// Latency : read combinational (pre-write contents in the write cycle); write lands on clk.
// Backpressure: none.
// Ports: clk, reset (async high); rd_idx_i -> rd_ctr_o; upd_en_i/upd_idx_i/upd_taken_i
// saturating step; set_en_i/set_val_i load (set wins over step).
module bpred_btb_pht
  import bpred_btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             set_en_i,
  input  logic [CTR_W-1:0] set_val_i
);
  localparam logic [CTR_W-1:0] CTR_INIT_NT = CTR_W'(ctr_init_nt(CTR_W));

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_comb begin
    ctr_d = ctr_q[upd_idx_i];
    if (upd_taken_i) ctr_d = CTR_W'(sat_inc(ctr_t'(ctr_q[upd_idx_i]), CTR_W));
    else             ctr_d = CTR_W'(sat_dec(ctr_t'(ctr_q[upd_idx_i]), CTR_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT_NT;
    end else if (set_en_i) begin
      ctr_q[upd_idx_i] <= set_val_i;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end
endmodule

// File: rtl/bpred_btb.sv
// Purpose : tagged BTB + saturating-counter direction predictor with perf counters.
// Latency : IF lookup combinational; mispredict/redirect_pc registered 1 cycle after upd_valid.
// Backpressure: none; one lookup and one resolution accepted every cycle.
// Ports: clk, reset (async high), bus (bpred_btb_if.slave: pred_*, upd_*, mispredict,
// redirect_pc, perf_*). Build option GSHARE_EN: counters move to a gshare PHT indexed
// by idx ^ GHR; otherwise counters sit alongside each BTB entry and pred_ghr is 0.
module bpred_btb
  import bpred_btb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 6
) (
  input logic          clk,
  input logic          reset,
  bpred_btb_if.slave   bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_ALLOC_T = CTR_W'(ctr_alloc_t(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             is_jump;
  } btb_entry_t;

  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       p_ent, u_ent;
  logic [IDX_W-1:0] p_idx, u_idx, p_pht_idx, u_pht_idx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic             p_hit, u_hit, u_ctrl, u_alias, u_mp;
  logic [CTR_W-1:0] p_ctr;
  logic             pht_upd_en, pht_set_en;
  logic [GHR_W-1:0] ghr_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [31:0]      perf_br_q, perf_mp_q;

  assign p_idx = IDX_W'(idx_of(64'(bus.pred_pc), IDX_W));
  assign p_tag = TAG_W'(tag_of(64'(bus.pred_pc), IDX_W, TAG_W));
  assign u_idx = IDX_W'(idx_of(64'(bus.upd_pc), IDX_W));
  assign u_tag = TAG_W'(tag_of(64'(bus.upd_pc), IDX_W, TAG_W));

  assign p_ent = btb_q[p_idx];
  assign u_ent = btb_q[u_idx];
  assign p_hit = p_ent.valid && (p_ent.tag == p_tag);
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  // Lookup reads the flops directly, so a same-cycle update is not visible yet.
  assign bus.pred_hit    = bus.pred_valid & p_hit;
  assign bus.pred_taken  = bus.pred_valid & p_hit & (p_ent.is_jump | p_ctr[CTR_W-1]);
  assign bus.pred_target = bus.pred_taken ? p_ent.target : bus.pred_pc + XLEN'(4);
  assign bus.pred_ghr    = ghr_q;

  assign u_ctrl  = bus.upd_is_branch | bus.upd_is_jump;
  // A non-control instruction that was predicted taken hit a stale/aliased entry.
  assign u_alias = ~u_ctrl & bus.upd_pred_taken;
  assign u_mp    = (bus.upd_taken != bus.upd_pred_taken)
                 | (bus.upd_taken & (bus.upd_target != bus.upd_pred_target))
                 | u_alias;
  assign redirect_d = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr_d;

  assign p_pht_idx  = p_idx ^ IDX_W'(ghr_q);
  assign u_pht_idx  = u_idx ^ IDX_W'(bus.upd_ghr);
  assign pht_upd_en = bus.upd_valid & bus.upd_is_branch;
  assign pht_set_en = 1'b0;

  // History is committed at resolution; on a mispredict rebuild it from the
  // snapshot that travelled with the branch rather than the live register.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.upd_valid && bus.upd_is_branch) begin
      if (u_mp) ghr_d = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
      else      ghr_d = {ghr_q[GHR_W-2:0], bus.upd_taken};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign ghr_q      = '0;
  assign p_pht_idx  = p_idx;
  assign u_pht_idx  = u_idx;
  assign pht_upd_en = bus.upd_valid & u_ctrl & u_hit;
  assign pht_set_en = bus.upd_valid & u_ctrl & ~u_hit & bus.upd_taken;
`endif

  bpred_btb_pht #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W)
  ) u_pht (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (p_pht_idx),
    .rd_ctr_o    (p_ctr),
    .upd_en_i    (pht_upd_en),
    .upd_idx_i   (u_pht_idx),
    .upd_taken_i (bus.upd_taken),
    .set_en_i    (pht_set_en),
    .set_val_i   (CTR_ALLOC_T)
  );

  // Taken control flow writes the whole entry: on a hit the tag is unchanged,
  // on a miss this is the allocation (overwrite of whatever shared the index).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (bus.upd_valid) begin
      if (u_ctrl && bus.upd_taken) begin
        btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: bus.upd_target,
                          is_jump: bus.upd_is_jump};
      end else if (u_alias && u_hit) begin
        btb_q[u_idx].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      perf_br_q    <= '0;
      perf_mp_q    <= '0;
    end else begin
      mispredict_q <= bus.upd_valid & u_mp;
      if (bus.upd_valid) redirect_q <= redirect_d;
      if (bus.upd_valid && u_ctrl && (perf_br_q != '1)) perf_br_q <= perf_br_q + 32'd1;
      if (bus.upd_valid && u_mp && (perf_mp_q != '1))   perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mp_q;
endmodule

// File: tb/tb_bpred_btb.sv
// Bench for bpred_btb: directed vectors, a behavioural predictor model compared
// every negedge, and literal expectations at key points of each scenario.
module tb_bpred_btb;
  localparam int XLEN = 32, ENTRIES = 64, TAG_W = 10, CTR_W = 2, GHR_W = 6;
  localparam int CMAX = (1 << CTR_W) - 1;
  localparam int CHALF = 1 << (CTR_W - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bpred_btb_if #(.XLEN(XLEN), .GHR_W(GHR_W)) bus ();
  bpred_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .GHR_W(GHR_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  bit run_chk = 0;

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_jmp   [ENTRIES];
  int          m_ctr   [ENTRIES];   // per-entry counter, or gshare PHT
  int          m_ghr;
  logic        e_mp;
  logic [31:0] e_redir, m_pb, m_pm;

  function automatic int m_idx(input logic [31:0] pc);
    return int'(pc / 4) % ENTRIES;
  endfunction
  function automatic int m_tagf(input logic [31:0] pc);
    return int'(pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jmp[i] = 0; m_ctr[i] = CHALF - 1;
    end
    m_ghr = 0; e_mp = 0; e_redir = 0; m_pb = 0; m_pm = 0;
  endtask

  function automatic void exp_pred(input logic [31:0] pc, input logic v,
                                   output logic h, output logic t, output logic [31:0] tg);
    int i, c;
    i = m_idx(pc);
`ifdef GSHARE_EN
    c = m_ctr[i ^ m_ghr];
`else
    c = m_ctr[i];
`endif
    h = v && m_valid[i] && (m_tag[i] == m_tagf(pc));
    t = h && (m_jmp[i] || c >= CHALF);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic m_update();
    int i; bit ctrl, hit, mp, tk;
    i = m_idx(bus.upd_pc);
    tk = bus.upd_taken;
    ctrl = bus.upd_is_branch || bus.upd_is_jump;
    hit = m_valid[i] && (m_tag[i] == m_tagf(bus.upd_pc));
    mp = (tk != bus.upd_pred_taken) || (tk && bus.upd_target != bus.upd_pred_target)
         || (!ctrl && bus.upd_pred_taken);
    e_mp = mp;
    e_redir = tk ? bus.upd_target : bus.upd_pc + 32'd4;
    if (ctrl && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
    if (mp && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
`ifdef GSHARE_EN
    if (bus.upd_is_branch) begin
      int pi;
      pi = i ^ int'(bus.upd_ghr);
      m_ctr[pi] = tk ? ((m_ctr[pi] < CMAX) ? m_ctr[pi] + 1 : CMAX)
                     : ((m_ctr[pi] > 0) ? m_ctr[pi] - 1 : 0);
      m_ghr = ((mp ? int'(bus.upd_ghr) : m_ghr) * 2 + int'(tk)) % (1 << GHR_W);
    end
`else
    if (ctrl && hit)
      m_ctr[i] = tk ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                    : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
    else if (ctrl && tk)
      m_ctr[i] = CHALF;
`endif
    if (ctrl && tk) begin
      m_valid[i] = 1; m_tag[i] = m_tagf(bus.upd_pc); m_tgt[i] = bus.upd_target;
      m_jmp[i] = bus.upd_is_jump;
    end else if (!ctrl && bus.upd_pred_taken && hit) begin
      m_valid[i] = 0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else if (bus.upd_valid) m_update();
    else e_mp = 0;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      logic h, t; logic [31:0] tg;
      exp_pred(bus.pred_pc, bus.pred_valid, h, t, tg);
      chk("model pred_hit", 64'(bus.pred_hit), 64'(h));
      chk("model pred_taken", 64'(bus.pred_taken), 64'(t));
      chk("model pred_target", 64'(bus.pred_target), 64'(tg));
      chk("model pred_ghr", 64'(bus.pred_ghr), 64'(m_ghr));
      chk("model mispredict", 64'(bus.mispredict), 64'(e_mp));
      chk("model redirect_pc", 64'(bus.redirect_pc), 64'(e_redir));
      chk("model perf_branches", 64'(bus.perf_branches), 64'(m_pb));
      chk("model perf_mispredicts", 64'(bus.perf_mispredicts), 64'(m_pm));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic v = 1'b1);
    bus.pred_valid = v; bus.pred_pc = pc; #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_is_branch = br; bus.upd_is_jump = jmp;
    bus.upd_taken = tk; bus.upd_target = tgt; bus.upd_pred_taken = ptk;
    bus.upd_pred_target = ptgt; bus.upd_ghr = GHR_W'(m_ghr);
  endtask

  task automatic upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    set_upd(pc, br, jmp, tk, tgt, ptk, ptgt);
    step();
    bus.upd_valid = 0;
  endtask

  task automatic expect_pred(input string nm, input logic h, input logic t, input logic [31:0] tg);
    chk({nm, " hit"}, 64'(bus.pred_hit), 64'(h));
    chk({nm, " taken"}, 64'(bus.pred_taken), 64'(t));
    chk({nm, " target"}, 64'(bus.pred_target), 64'(tg));
  endtask

  initial begin
    bus.pred_valid = 0; bus.pred_pc = 0;
    bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_is_branch = 0; bus.upd_is_jump = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.upd_pred_taken = 0;
    bus.upd_pred_target = 0; bus.upd_ghr = 0;
    m_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    run_chk = 1;

    // 1: reset state
    lookup(32'h100);
    expect_pred("t1", 0, 0, 32'h104);
    chk("t1 perf_branches", 64'(bus.perf_branches), 0);
    chk("t1 perf_mispredicts", 64'(bus.perf_mispredicts), 0);
    chk("t1 mispredict", 64'(bus.mispredict), 0);
    chk("t1 redirect_pc", 64'(bus.redirect_pc), 0);

`ifndef GSHARE_EN
    // 2: first taken branch allocates and mispredicts
    upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    chk("t2 mispredict", 64'(bus.mispredict), 1);
    chk("t2 redirect_pc", 64'(bus.redirect_pc), 64'h80);
    chk("t2 perf_branches", 64'(bus.perf_branches), 1);
    chk("t2 perf_mispredicts", 64'(bus.perf_mispredicts), 1);
    lookup(32'h100);
    expect_pred("t2 lookup", 1, 1, 32'h80);
    lookup(32'h100, 0);
    expect_pred("t2 pred_valid=0", 0, 0, 32'h104);

    // 3: counter 2 -> 3 (sat), then down to 0 (sat) and back up
    repeat (3) upd(32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
    chk("t3 correct no mispredict", 64'(bus.mispredict), 0);
    upd(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    chk("t3 nt mispredict", 64'(bus.mispredict), 1);
    chk("t3 nt redirect", 64'(bus.redirect_pc), 64'h104);
    lookup(32'h100);
    expect_pred("t3 ctr2", 1, 1, 32'h80);
    upd(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    lookup(32'h100);
    expect_pred("t3 ctr1", 1, 0, 32'h104);
    upd(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
    upd(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
    lookup(32'h100);
    expect_pred("t3 ctr0 no wrap", 1, 0, 32'h104);
    upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    lookup(32'h100);
    expect_pred("t3 ctr1 again", 1, 0, 32'h104);
    upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    lookup(32'h100);
    expect_pred("t3 ctr2 again", 1, 1, 32'h80);

    // 4: 0x200 shares the index with a different tag
    lookup(32'h200);
    expect_pred("t4 0x200 miss", 0, 0, 32'h204);
    upd(32'h200, 0, 1, 1, 32'h300, 0, 32'h204);
    lookup(32'h100);
    expect_pred("t4 0x100 evicted", 0, 0, 32'h104);
    lookup(32'h200);
    expect_pred("t4 jal hit", 1, 1, 32'h300);
    upd(32'h200, 0, 0, 0, 32'h0, 1, 32'h300);
    chk("t4 alias mispredict", 64'(bus.mispredict), 1);
    chk("t4 alias redirect", 64'(bus.redirect_pc), 64'h204);
    lookup(32'h200);
    expect_pred("t4 alias invalidated", 0, 0, 32'h204);

    // 5: read-before-write, then reset in the middle of an update
    upd(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    lookup(32'h100);
    set_upd(32'h100, 1, 0, 1, 32'h180, 1, 32'h80);
    #1;
    expect_pred("t5 same-cycle old", 1, 1, 32'h80);
    step();
    bus.upd_valid = 0;
    #1;
    expect_pred("t5 after write", 1, 1, 32'h180);
    step();
    set_upd(32'h100, 1, 0, 1, 32'h280, 0, 32'h104);
    #2 reset = 1;
    #1;
    expect_pred("t5 in reset", 0, 0, 32'h104);
    chk("t5 rst mispredict", 64'(bus.mispredict), 0);
    chk("t5 rst redirect", 64'(bus.redirect_pc), 0);
    chk("t5 rst perf_branches", 64'(bus.perf_branches), 0);
    chk("t5 rst perf_mispredicts", 64'(bus.perf_mispredicts), 0);
    @(posedge clk);
    #1 bus.upd_valid = 0;
    #1 reset = 0;
    lookup(32'h100);
    expect_pred("t5 update discarded", 0, 0, 32'h104);
    step();
    chk("t5 post-reset mispredict", 64'(bus.mispredict), 0);

    // 6: perf_mispredicts saturation
    force dut.perf_mp_q = 32'hFFFF_FFFE;
    m_pm = 32'hFFFF_FFFE;
    #1 release dut.perf_mp_q;
    repeat (3) upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44);
    chk("t6 perf_mispredicts sat", 64'(bus.perf_mispredicts), 64'hFFFF_FFFF);
    chk("t6 perf_branches", 64'(bus.perf_branches), 3);
`else
    // 6 (gshare): alternating T/N at 0x40 must train to zero mispredicts
    begin
      logic h, t; logic [31:0] tg; logic [31:0] base; logic tk;
      base = 0;
      for (int k = 0; k < 32; k++) begin
        tk = (k % 2 == 0);
        lookup(32'h40);
        exp_pred(32'h40, 1'b1, h, t, tg);
        upd(32'h40, 1, 0, tk, 32'h80, t, tg);
        if (k == 15) base = bus.perf_mispredicts;
      end
      chk("t6 gshare warm mispredicts", 64'(bus.perf_mispredicts - base), 0);
      chk("t6 gshare branches", 64'(bus.perf_branches), 32);
    end
`endif

    step();
    run_chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
